// File: rtl/fft_ctrl_pkg.sv
// Shared types and defaults for the FFT frame controller.
// Imported by the controller, its buffer and the FFT instance.
package fft_ctrl_pkg;

   typedef enum logic [1:0] {
      LOAD,
      SETTLE,
      CAPTURE,
      DRAIN
   } fft_ctrl_state_t;

   localparam int DEF_SAMPLES = 8;
   localparam int DEF_WIDTH   = 32;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fft_frame_buffer.sv
// SAMPLES x WIDTH register array: indexed write,
// whole-array parallel load and parallel read.
module fft_frame_buffer
   import fft_ctrl_pkg::*;
#(
   parameter int SAMPLES = DEF_SAMPLES,
   parameter int WIDTH   = DEF_WIDTH,
   localparam int IW     = idx_width(SAMPLES)
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            wr_en,
   input  logic [IW-1:0]                   wr_idx,
   input  logic [WIDTH-1:0]                wr_data,
   input  logic                            load_en,
   input  logic [SAMPLES-1:0][WIDTH-1:0]   load_data,
   output logic [SAMPLES-1:0][WIDTH-1:0]   data
);

   logic [SAMPLES-1:0][WIDTH-1:0] mem;

   // Parallel load wins over the single-word write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem <= '0;
      end else if (load_en) begin
         mem <= load_data;
      end else if (wr_en) begin
         mem[wr_idx] <= wr_data;
      end
   end

   assign data = mem;

endmodule

// File: rtl/fft_frame_controller.sv
// Streams a frame into a combinational FFT, waits for it
// to settle, captures the results and drains them.
module fft_frame_controller
   import fft_ctrl_pkg::*;
#(
   parameter int SAMPLES       = DEF_SAMPLES,
   parameter int WIDTH         = DEF_WIDTH,
   parameter int SETTLE_CYCLES = 2,
   localparam int IW           = idx_width(SAMPLES)
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [WIDTH-1:0]                in_data,
   output logic [SAMPLES-1:0][WIDTH-1:0]   fft_inputs,
   input  logic [SAMPLES-1:0][WIDTH-1:0]   fft_outputs,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [WIDTH-1:0]                out_data,
   output logic [IW-1:0]                   out_index,
   output logic                            out_last,
   output logic                            busy
);

   localparam int SW = $clog2(SETTLE_CYCLES + 1);
   localparam logic [IW-1:0] LAST_IDX = IW'(SAMPLES - 1);
   localparam logic [SW-1:0] LAST_SET = SW'(SETTLE_CYCLES - 1);

   fft_ctrl_state_t state, next;
   logic [IW-1:0] wr_idx;
   logic [IW-1:0] rd_idx;
   logic [SW-1:0] settle_cnt;
   logic [SAMPLES-1:0][WIDTH-1:0] result;
   logic wr_en;
   logic rd_en;
   logic is_drain;

   assign in_ready = (state == LOAD);
   assign is_drain = (state == DRAIN);
   assign busy     = (state != LOAD);
   assign wr_en    = in_ready && in_valid;
   assign rd_en    = is_drain && out_ready;

   assign out_valid = is_drain;
   assign out_index = rd_idx;
   assign out_last  = is_drain && (rd_idx == LAST_IDX);
   assign out_data  = is_drain ? result[rd_idx] : '0;

   fft_frame_buffer #(
      .SAMPLES (SAMPLES),
      .WIDTH   (WIDTH)
   ) u_frame (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (wr_en),
      .wr_idx    (wr_idx),
      .wr_data   (in_data),
      .load_en   (1'b0),
      .load_data ('0),
      .data      (fft_inputs)
   );

   fft_frame_buffer #(
      .SAMPLES (SAMPLES),
      .WIDTH   (WIDTH)
   ) u_result (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (1'b0),
      .wr_idx    ('0),
      .wr_data   ('0),
      .load_en   (state == CAPTURE),
      .load_data (fft_outputs),
      .data      (result)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= LOAD;
      end else begin
         state <= next;
      end
   end

   // Next-state decode.
   always_comb begin
      next = state;
      unique case (state)
         LOAD: begin
            if (wr_en && wr_idx == LAST_IDX) next = SETTLE;
         end
         SETTLE: begin
            if (settle_cnt == LAST_SET) next = CAPTURE;
         end
         CAPTURE: next = DRAIN;
         DRAIN: begin
            if (rd_en && rd_idx == LAST_IDX) next = LOAD;
         end
         default: next = LOAD;
      endcase
   end

   // Write/read pointers wrap naturally; settle count
   // runs only in SETTLE and is zero on entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_idx     <= '0;
         rd_idx     <= '0;
         settle_cnt <= '0;
      end else begin
         if (wr_en) wr_idx <= wr_idx + IW'(1);
         if (state == CAPTURE) begin
            rd_idx <= '0;
         end else if (rd_en) begin
            rd_idx <= rd_idx + IW'(1);
         end
         if (state == SETTLE) begin
            settle_cnt <= settle_cnt + SW'(1);
         end else begin
            settle_cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_fft_frame_controller.sv
// Scoreboard bench for fft_frame_controller with a stub
// FFT that adds the bin index to each frame word.
module tb_fft_frame_controller;

   localparam int N = 8;
   localparam int W = 32;

   typedef struct {
      logic [W-1:0] d;
      int           idx;
      bit           last;
   } exp_t;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                in_valid;
   logic                in_ready;
   logic [W-1:0]        in_data;
   logic [N-1:0][W-1:0] fft_inputs;
   logic [N-1:0][W-1:0] fft_outputs;
   logic                out_valid;
   logic                out_ready;
   logic [W-1:0]        out_data;
   logic [2:0]          out_index;
   logic                out_last;
   logic                busy;

   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   accept_cyc = 0;
   bit   lat_arm = 0;
   bit   ready_chk = 0;
   exp_t q[$];
   logic [W-1:0]        frm [N];
   logic [N-1:0][W-1:0] exp_frame = '0;

   fft_frame_controller #(
      .SAMPLES       (N),
      .WIDTH         (W),
      .SETTLE_CYCLES (2)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .fft_inputs  (fft_inputs),
      .fft_outputs (fft_outputs),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_index   (out_index),
      .out_last    (out_last),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always_comb begin
      for (int i = 0; i < N; i++)
         fft_outputs[i] = fft_inputs[i] + W'(i);
   end

   task automatic chk(input string name,
                      input longint act,
                      input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d",
                  name, act, exp);
      end
   endtask

   task automatic send(input logic [W-1:0] d, input int i);
      int n = 0;
      in_valid = 1'b1;
      in_data  = d;
      while (!in_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("send_wait_in_ready", in_ready, 1);
      @(posedge clk); #1;
      in_valid   = 1'b0;
      exp_frame[i] = d;
      accept_cyc = cyc;
   endtask

   task automatic load_frame(input bit gaps);
      for (int i = 0; i < N; i++)
         q.push_back('{d: frm[i] + W'(i), idx: i,
                       last: (i == N - 1)});
      for (int i = 0; i < N; i++) begin
         send(frm[i], i);
         if (gaps && i < N - 1) begin
            @(posedge clk); #1;
         end
      end
      lat_arm = 1'b1;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      chk("wait_idle_timeout", busy, 0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_out_valid"}, out_valid, 0);
      chk({tag, "_in_ready"}, in_ready, 1);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_out_last"}, out_last, 0);
      chk({tag, "_out_data"}, out_data, 0);
      chk({tag, "_out_index"}, out_index, 0);
      chk({tag, "_fft_inputs"}, fft_inputs == '0, 1);
   endtask

   // Monitor: sampled on the falling edge.
   always @(negedge clk) begin
      if (rst_n) begin
         if (ready_chk) begin
            chk("in_ready_after_last", in_ready, 1);
            ready_chk = 1'b0;
         end
         if (busy) begin
            chk("in_ready_while_busy", in_ready, 0);
            chk("frame_frozen", fft_inputs == exp_frame, 1);
         end
         if (out_valid) begin
            if (lat_arm) begin
               chk("first_valid_latency", cyc - accept_cyc, 3);
               lat_arm = 1'b0;
            end
            if (q.size() == 0) begin
               chk("unexpected_output", out_valid, 0);
            end else begin
               chk("out_data", out_data, q[0].d);
               chk("out_index", out_index, q[0].idx);
               chk("out_last", out_last, q[0].last);
               if (out_ready) begin
                  if (q[0].last) ready_chk = 1'b1;
                  void'(q.pop_front());
               end
            end
         end
      end
   end

   initial begin
      int n;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      #2;
      chk_reset_outputs("por");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      chk_reset_outputs("idle");

      frm = '{80, 70, 50, 40, 60, 10, 80, 90};

      // full-rate frame
      out_ready = 1'b1;
      load_frame(1'b0);
      wait_idle();

      // input gaps
      load_frame(1'b1);
      wait_idle();

      // back-pressure at bin 3
      out_ready = 1'b0;
      load_frame(1'b0);
      n = 0;
      while (!out_valid && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk("bp_wait_valid", out_valid, 1);
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 out_ready = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("bp_hold_data", out_data, 43);
      chk("bp_hold_index", out_index, 3);
      out_ready = 1'b1;
      wait_idle();

      // ignored traffic during SETTLE/DRAIN
      load_frame(1'b0);
      in_valid = 1'b1;
      in_data  = 999;
      n = 0;
      while (busy && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      in_valid = 1'b0;
      chk("ignored_wait_idle", busy, 0);

      // back-to-back frames
      load_frame(1'b0);
      frm = '{1, 2, 3, 4, 5, 6, 7, 8};
      load_frame(1'b0);
      wait_idle();

      // reset mid-drain
      frm = '{80, 70, 50, 40, 60, 10, 80, 90};
      load_frame(1'b0);
      n = 0;
      while (!(out_valid && out_index == 2) && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk("rst_wait_bin2", out_index, 2);
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("mid_drain");
      q.delete();
      lat_arm   = 1'b0;
      ready_chk = 1'b0;
      exp_frame = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      chk_reset_outputs("post_rst");

      chk("queue_empty", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fft_frame_controller.md
# fft_frame_controller

Sequencing controller for the combinational N-point FFT datapath. It collects a frame of `SAMPLES` words from a valid/ready input stream into a frame register and presents the frame to the FFT core as stable parallel inputs. It then waits a programmable settle time, captures the parallel FFT results, and drains them one word per handshake on an output stream. It lets the combinational FFT sit between clocked streaming logic without glitching or mid-frame input changes.

## Interface
Parameters:
- `SAMPLES`, 8: frame length; power of two, ≥ 2.
- `WIDTH`, 32: word width of samples and results.
- `SETTLE_CYCLES`, 2: cycles the frame is held stable before capture; ≥ 1.

Ports:
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `in_valid`  in  1  input sample valid.
- `in_ready`  out  1  controller can accept a sample.
- `in_data`  in  WIDTH  input sample.
- `fft_inputs`  out  WIDTH × SAMPLES  frame driven to the FFT `sampleInputs`.
- `fft_outputs`  in  WIDTH × SAMPLES  FFT `outputs`.
- `out_valid`  out  1  result word valid.
- `out_ready`  in  1  downstream accepts the result word.
- `out_data`  out  WIDTH  result word.
- `out_index`  out  $clog2(SAMPLES)  bin index of `out_data`.
- `out_last`  out  1  high with `out_valid` on bin SAMPLES-1.
- `busy`  out  1  high in any state other than LOAD.

## Operation
- States: LOAD, SETTLE, CAPTURE, DRAIN.
- LOAD:
  - `in_ready`=1.
  - Each `in_valid && in_ready` writes `in_data` to frame[wr_idx] and increments wr_idx.
  - The accept at wr_idx = SAMPLES-1 moves to SETTLE with settle_cnt = 0. wr_idx wraps to 0.
- SETTLE:
  - `in_ready`=0. The frame is frozen.
  - settle_cnt increments each cycle. When settle_cnt = SETTLE_CYCLES-1, move to CAPTURE.
- CAPTURE: one cycle. Latch all of `fft_outputs` into the result register, set rd_idx = 0, move to DRAIN.
- DRAIN:
  - `out_valid`=1, `out_data`=result[rd_idx], `out_index`=rd_idx, `out_last`=(rd_idx = SAMPLES-1).
  - Each `out_valid && out_ready` increments rd_idx.
  - The handshake with `out_last` moves to LOAD and wraps rd_idx to 0.
- `fft_inputs` = frame register at all times. It changes only on LOAD accepts.
- Counter widths: wr_idx and rd_idx are $clog2(SAMPLES) bits. settle_cnt is $clog2(SETTLE_CYCLES+1) bits. Wrap is natural modulo because SAMPLES is a power of two.
- `in_valid` while not in LOAD is ignored; no data is taken.
- `out_ready` while not in DRAIN is ignored.
- Data is never modified; the controller is width-transparent.

## Timing
- Reset, while `rst_n`=0, asynchronous:
  - State = LOAD.
  - wr_idx, rd_idx, settle_cnt = 0.
  - frame and result registers = 0.
  - `in_ready`=1, `out_valid`=0, `out_last`=0, `busy`=0, `out_data`=0, `out_index`=0, `fft_inputs`=all 0.
- Reset mid-operation (any state) aborts the frame. All of the above applies immediately, and a partially loaded or undrained frame is lost.
- Latency, final input accept (edge E) to first `out_valid`: SETTLE_CYCLES + 1 cycles. SETTLE occupies E+1..E+SETTLE_CYCLES, CAPTURE one cycle, and `out_valid` is high from the following cycle.
- All outputs are registered or decoded from registered state only. There is no combinational path from `in_valid` or `out_ready` to any output.
- Back-pressure: `out_valid`, `out_data` and `out_index` hold stable while `out_ready`=0.
- Throughput: one frame per SAMPLES + SETTLE_CYCLES + 1 + SAMPLES cycles at full rate; load and drain do not overlap.
- `in_ready` rises on the cycle after the `out_last` handshake.
- Combinational path through the FFT must close within SETTLE_CYCLES clock periods. Implementation sets the matching multicycle constraint from fft_inputs to the result registers.

## Structure
- Package `fft_ctrl_pkg`:
  - state enum `fft_ctrl_state_t` (LOAD, SETTLE, CAPTURE, DRAIN).
  - localparam function for index width.
  - default SAMPLES/WIDTH constants shared with the FFT instance.
- One sub-module, `fft_frame_buffer`:
  - SAMPLES×WIDTH register array with indexed write port and parallel read port.
  - Instantiated twice: once as the frame register, once as the result register (parallel load, indexed read).
- The FFT core is instantiated by the parent, not inside this block.

## Test plan
- Reset: assert `rst_n`=0 mid-DRAIN → same cycle `out_valid`=0, `in_ready`=1, `busy`=0, `fft_inputs` all 0.
- Full-rate frame with stub FFT (`fft_outputs[i]` = `fft_inputs[i]` + i), inputs 80,70,50,40,60,10,80,90, `out_ready`=1:
  - outputs are 80,71,52,43,64,15,86,97 at indices 0..7.
  - `out_last` only on index 7.
  - first `out_valid` exactly 3 cycles after the 8th accept.
- Input gaps: `in_valid` toggled 1,0,1,0 across the same 8 samples → identical outputs, and `fft_inputs` unchanged during SETTLE.
- Back-pressure: `out_ready`=0 for 5 cycles at index 3 → `out_data`=43 and `out_index`=3 held, no skipped or repeated bins.
- Ignored traffic: `in_valid`=1 with data 999 throughout SETTLE and DRAIN → `in_ready`=0 and 999 never appears in `fft_inputs`.
- Back-to-back frames: second frame 1..8 loaded immediately after the first `out_last` → outputs 1,3,5,7,9,11,13,15, and `in_ready` reasserts the cycle after `out_last`.
